// File: rtl/cpu54_pkg.sv
// cpu54_pkg
//   Shared encodings for the CPU_54 decode path: MIPS opcode/function
//   field values, the rs/rt selectors used by COP0 and REGIMM, the
//   one-hot bit index of every supported instruction, and the
//   occupancy states of the decode-stage skid buffer.
package cpu54_pkg;

  localparam int NUM_INSTR_DEF = 54;
  localparam int ID_W          = 6;

  typedef logic [ID_W-1:0] id_t;

  // Buffer occupancy: M alone, or M plus the skid entry S.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_REGIMM = 6'b000001, OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011, OP_BEQ    = 6'b000100, OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000, OP_ADDIU  = 6'b001001, OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011, OP_ANDI   = 6'b001100, OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110, OP_LUI    = 6'b001111, OP_COP0  = 6'b010000;
  localparam logic [5:0] OP_SPEC2 = 6'b011100, OP_LB     = 6'b100000, OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011, OP_LBU    = 6'b100100, OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000, OP_SH     = 6'b101001, OP_SW    = 6'b101011;

  // Function codes (instr[5:0]) for OP_RTYPE, plus ERET (COP0) and CLZ (SPECIAL2)
  localparam logic [5:0] FUNC_SLL   = 6'b000000, FUNC_SRL   = 6'b000010, FUNC_SRA   = 6'b000011;
  localparam logic [5:0] FUNC_SLLV  = 6'b000100, FUNC_SRLV  = 6'b000110, FUNC_SRAV  = 6'b000111;
  localparam logic [5:0] FUNC_JR    = 6'b001000, FUNC_JALR  = 6'b001001, FUNC_SYSCALL = 6'b001100;
  localparam logic [5:0] FUNC_BREAK = 6'b001101, FUNC_MFHI  = 6'b010000, FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010, FUNC_MTLO  = 6'b010011, FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001, FUNC_DIV   = 6'b011010, FUNC_DIVU  = 6'b011011;
  localparam logic [5:0] FUNC_ADD   = 6'b100000, FUNC_ADDU  = 6'b100001, FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_SUBU  = 6'b100011, FUNC_AND   = 6'b100100, FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_XOR   = 6'b100110, FUNC_NOR   = 6'b100111, FUNC_SLT   = 6'b101010;
  localparam logic [5:0] FUNC_SLTU  = 6'b101011, FUNC_TEQ   = 6'b110100;
  localparam logic [5:0] FUNC_ERET  = 6'b011000, FUNC_CLZ   = 6'b100000;

  // rs selectors under COP0, rt selector under REGIMM
  localparam logic [4:0] RS_MF = 5'b00000, RS_MT = 5'b00100, RS_CO = 5'b10000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  // One-hot bit positions
  localparam id_t ID_ADD  = 6'd0,  ID_ADDU  = 6'd1,  ID_SUB   = 6'd2,  ID_SUBU    = 6'd3;
  localparam id_t ID_AND  = 6'd4,  ID_OR    = 6'd5,  ID_XOR   = 6'd6,  ID_NOR     = 6'd7;
  localparam id_t ID_SLT  = 6'd8,  ID_SLTU  = 6'd9,  ID_SLL   = 6'd10, ID_SRL     = 6'd11;
  localparam id_t ID_SRA  = 6'd12, ID_SLLV  = 6'd13, ID_SRLV  = 6'd14, ID_SRAV    = 6'd15;
  localparam id_t ID_JR   = 6'd16, ID_JALR  = 6'd17, ID_SYSCALL = 6'd18, ID_BREAK = 6'd19;
  localparam id_t ID_MFHI = 6'd20, ID_MTHI  = 6'd21, ID_MFLO  = 6'd22, ID_MTLO    = 6'd23;
  localparam id_t ID_MULT = 6'd24, ID_MULTU = 6'd25, ID_DIVU  = 6'd26, ID_TEQ     = 6'd27;
  localparam id_t ID_ADDI = 6'd28, ID_ADDIU = 6'd29, ID_ANDI  = 6'd30, ID_ORI     = 6'd31;
  localparam id_t ID_XORI = 6'd32, ID_LUI   = 6'd33, ID_LW    = 6'd34, ID_SW      = 6'd35;
  localparam id_t ID_BEQ  = 6'd36, ID_BNE   = 6'd37, ID_SLTI  = 6'd38, ID_SLTIU   = 6'd39;
  localparam id_t ID_J    = 6'd40, ID_JAL   = 6'd41, ID_LB    = 6'd42, ID_LBU     = 6'd43;
  localparam id_t ID_LH   = 6'd44, ID_LHU   = 6'd45, ID_SB    = 6'd46, ID_SH      = 6'd47;
  localparam id_t ID_BGEZ = 6'd48, ID_CLZ   = 6'd49, ID_MFC0  = 6'd50, ID_MTC0    = 6'd51;
  localparam id_t ID_ERET = 6'd52, ID_DIV   = 6'd53;

endpackage

// File: rtl/instr_decode_comb.sv
// instr_decode_comb
//   Pure combinational MIPS decoder: one 32-bit word in, one-hot code out.
//   Unknown or reserved encodings give an all-zero code with illegal=1,
//   so exactly one of {code bits, illegal} is ever set.
// Ports
//   instr    in   32         instruction word
//   code     out  NUM_INSTR  one-hot decode (bit positions from cpu54_pkg ID_*)
//   illegal  out  1          encoding not recognised
module instr_decode_comb
  import cpu54_pkg::*;
#(
  parameter int NUM_INSTR = NUM_INSTR_DEF
) (
  input  logic [31:0]          instr,
  output logic [NUM_INSTR-1:0] code,
  output logic                 illegal
);

  logic [5:0] op;
  logic [5:0] func;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       hit;
  id_t        idx;
  logic       unused_fields;

  assign op   = instr[31:26];
  assign rs   = instr[25:21];
  assign rt   = instr[20:16];
  assign func = instr[5:0];

  // rd/shamt/immediate bits never influence which instruction this is
  assign unused_fields = ^instr[15:6];

  always_comb begin
    hit = 1'b1;
    idx = ID_ADD;
    case (op)
      OP_RTYPE: begin
        case (func)
          FUNC_ADD:   idx = ID_ADD;    FUNC_ADDU:  idx = ID_ADDU;
          FUNC_SUB:   idx = ID_SUB;    FUNC_SUBU:  idx = ID_SUBU;
          FUNC_AND:   idx = ID_AND;    FUNC_OR:    idx = ID_OR;
          FUNC_XOR:   idx = ID_XOR;    FUNC_NOR:   idx = ID_NOR;
          FUNC_SLT:   idx = ID_SLT;    FUNC_SLTU:  idx = ID_SLTU;
          FUNC_SLL:   idx = ID_SLL;    FUNC_SRL:   idx = ID_SRL;
          FUNC_SRA:   idx = ID_SRA;    FUNC_SLLV:  idx = ID_SLLV;
          FUNC_SRLV:  idx = ID_SRLV;   FUNC_SRAV:  idx = ID_SRAV;
          FUNC_JR:    idx = ID_JR;     FUNC_JALR:  idx = ID_JALR;
          FUNC_SYSCALL: idx = ID_SYSCALL;
          FUNC_BREAK: idx = ID_BREAK;  FUNC_MFHI:  idx = ID_MFHI;
          FUNC_MTHI:  idx = ID_MTHI;   FUNC_MFLO:  idx = ID_MFLO;
          FUNC_MTLO:  idx = ID_MTLO;   FUNC_MULT:  idx = ID_MULT;
          FUNC_MULTU: idx = ID_MULTU;  FUNC_DIV:   idx = ID_DIV;
          FUNC_DIVU:  idx = ID_DIVU;   FUNC_TEQ:   idx = ID_TEQ;
          default:    hit = 1'b0;
        endcase
      end
      // REGIMM only supports BGEZ; other rt values are reserved here
      OP_REGIMM: if (rt == RT_BGEZ) idx = ID_BGEZ; else hit = 1'b0;
      OP_SPEC2:  if (func == FUNC_CLZ) idx = ID_CLZ; else hit = 1'b0;
      // COP0 is split by rs; ERET additionally needs its function code
      OP_COP0: begin
        if (rs == RS_MF)                             idx = ID_MFC0;
        else if (rs == RS_MT)                        idx = ID_MTC0;
        else if (rs == RS_CO && func == FUNC_ERET)   idx = ID_ERET;
        else                                         hit = 1'b0;
      end
      OP_J:     idx = ID_J;      OP_JAL:   idx = ID_JAL;
      OP_BEQ:   idx = ID_BEQ;    OP_BNE:   idx = ID_BNE;
      OP_ADDI:  idx = ID_ADDI;   OP_ADDIU: idx = ID_ADDIU;
      OP_SLTI:  idx = ID_SLTI;   OP_SLTIU: idx = ID_SLTIU;
      OP_ANDI:  idx = ID_ANDI;   OP_ORI:   idx = ID_ORI;
      OP_XORI:  idx = ID_XORI;   OP_LUI:   idx = ID_LUI;
      OP_LB:    idx = ID_LB;     OP_LH:    idx = ID_LH;
      OP_LW:    idx = ID_LW;     OP_LBU:   idx = ID_LBU;
      OP_LHU:   idx = ID_LHU;    OP_SB:    idx = ID_SB;
      OP_SH:    idx = ID_SH;     OP_SW:    idx = ID_SW;
      default:  hit = 1'b0;
    endcase

    code = '0;
    if (hit) code[idx] = 1'b1;
    illegal = !hit;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//   Registered, valid/ready decode stage between fetch and control.
//   Each accepted word is decoded and captured together with its PC into
//   a 2-entry skid buffer (main register M drives the outputs, S catches
//   the one extra word that can arrive while the consumer stalls).
//   Also counts accepted illegal encodings in a saturating counter.
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  drop every buffered entry at the next edge
//   in_valid/in_ready      fetch handshake; in_instr, in_pc carried with it
//   out_valid/out_ready    consumer handshake
//   out_code, out_illegal  one-hot decode / illegal flag of the head entry
//   out_instr, out_pc      raw word and PC of the head entry
//   illegal_cnt            accepted illegal entries, saturating
module instr_decode_stage
  import cpu54_pkg::*;
#(
  parameter int INSTR_W   = 32,  // MIPS field slicing assumes 32
  parameter int NUM_INSTR = NUM_INSTR_DEF,
  parameter int PC_W      = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instr,
  input  logic [PC_W-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_INSTR-1:0] out_code,
  output logic                 out_illegal,
  output logic [INSTR_W-1:0]   out_instr,
  output logic [PC_W-1:0]      out_pc,
  output logic [CNT_W-1:0]     illegal_cnt
);

  buf_state_e             state_q, state_d;
  logic [NUM_INSTR-1:0]   m_code_q, m_code_d, s_code_q, s_code_d;
  logic                   m_ill_q, m_ill_d, s_ill_q, s_ill_d;
  logic [INSTR_W-1:0]     m_instr_q, m_instr_d, s_instr_q, s_instr_d;
  logic [PC_W-1:0]        m_pc_q, m_pc_d, s_pc_q, s_pc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_INSTR-1:0]   dec_code;
  logic                   dec_illegal;
  logic                   accept, drain;
  logic                   load_m_new, load_m_from_s, load_s;

  instr_decode_comb #(.NUM_INSTR(NUM_INSTR)) u_decode (
    .instr   (in_instr),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  // in_ready comes straight from the occupancy flop, so it never sees out_ready
  assign in_ready  = (state_q != BUF_TWO);
  assign out_valid = (state_q != BUF_EMPTY);

  // A word arriving together with flush is discarded and not counted
  assign accept = in_valid && in_ready && !flush;
  assign drain  = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    load_m_new     = 1'b0;
    load_m_from_s  = 1'b0;
    load_s         = 1'b0;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: if (accept) begin
          state_d    = BUF_ONE;
          load_m_new = 1'b1;
        end
        BUF_ONE: begin
          if (accept && drain) begin
            load_m_new = 1'b1;
          end else if (accept) begin
            state_d = BUF_TWO;
            load_s  = 1'b1;
          end else if (drain) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_TWO: if (drain) begin
          state_d       = BUF_ONE;
          load_m_from_s = 1'b1;
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // Datapath moves selected by the occupancy logic above
  always_comb begin
    m_code_d  = m_code_q;  m_ill_d = m_ill_q;  m_instr_d = m_instr_q;  m_pc_d = m_pc_q;
    s_code_d  = s_code_q;  s_ill_d = s_ill_q;  s_instr_d = s_instr_q;  s_pc_d = s_pc_q;
    if (load_m_new) begin
      m_code_d = dec_code;  m_ill_d = dec_illegal;  m_instr_d = in_instr;  m_pc_d = in_pc;
    end else if (load_m_from_s) begin
      m_code_d = s_code_q;  m_ill_d = s_ill_q;      m_instr_d = s_instr_q; m_pc_d = s_pc_q;
    end
    if (load_s) begin
      s_code_d = dec_code;  s_ill_d = dec_illegal;  s_instr_d = in_instr;  s_pc_d = in_pc;
    end
  end

  // Counts at acceptance, so entries flushed later are still included
  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec_illegal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BUF_EMPTY;
      m_code_q  <= '0;  m_ill_q <= 1'b0;  m_instr_q <= '0;  m_pc_q <= '0;
      s_code_q  <= '0;  s_ill_q <= 1'b0;  s_instr_q <= '0;  s_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      m_code_q  <= m_code_d;  m_ill_q <= m_ill_d;  m_instr_q <= m_instr_d;  m_pc_q <= m_pc_d;
      s_code_q  <= s_code_d;  s_ill_q <= s_ill_d;  s_instr_q <= s_instr_d;  s_pc_q <= s_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_code    = m_code_q;
  assign out_illegal = m_ill_q;
  assign out_instr   = m_instr_q;
  assign out_pc      = m_pc_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage
//   Directed vectors for instr_decode_stage. The driver pushes the
//   hand-derived expected entry when a word is accepted; a separate
//   monitor pops and compares whenever the DUT transfers an output.
//   A second instance with a 2-bit counter exercises saturation.
module tb_instr_decode_stage;
  import cpu54_pkg::*;

  typedef struct {
    logic [53:0] code;
    logic        ill;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        out_valid, out_ready;
  logic [53:0] out_code;
  logic        out_illegal;
  logic [31:0] out_instr, out_pc;
  logic [15:0] illegal_cnt;

  logic        sat_valid, sat_in_ready, sat_out_valid, sat_out_illegal;
  logic [31:0] sat_instr, sat_out_instr, sat_out_pc;
  logic [53:0] sat_out_code;
  logic [1:0]  sat_cnt;

  exp_t expq[$];
  int   checks  = 0;
  int   errors  = 0;
  int   exp_cnt = 0;

  instr_decode_stage #(.INSTR_W(32), .NUM_INSTR(54), .PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_illegal(out_illegal), .out_instr(out_instr), .out_pc(out_pc),
    .illegal_cnt(illegal_cnt)
  );

  instr_decode_stage #(.INSTR_W(32), .NUM_INSTR(54), .PC_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(sat_valid), .in_ready(sat_in_ready), .in_instr(sat_instr), .in_pc(32'h0),
    .out_valid(sat_out_valid), .out_ready(1'b1), .out_code(sat_out_code),
    .out_illegal(sat_out_illegal), .out_instr(sat_out_instr), .out_pc(sat_out_pc),
    .illegal_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares every output transfer against the head of the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_output actual instr=0x%08h pc=0x%08h required none", out_instr, out_pc);
        end else begin
          e = expq.pop_front();
          if (out_code !== e.code || out_illegal !== e.ill || out_instr !== e.instr || out_pc !== e.pc) begin
            errors++;
            $display("[TB] FAIL entry actual code=0x%0h ill=%0b instr=0x%08h pc=0x%08h required code=0x%0h ill=%0b instr=0x%08h pc=0x%08h",
                     out_code, out_illegal, out_instr, out_pc, e.code, e.ill, e.instr, e.pc);
          end
        end
      end
    end
  end

  // id < 0 means the word must decode as illegal
  task automatic applyStimulus(input logic [31:0] w, input logic [31:0] pc, input int id);
    exp_t e;
    bit   done;
    done    = 1'b0;
    e.instr = w;
    e.pc    = pc;
    e.ill   = (id < 0);
    e.code  = '0;
    if (id >= 0) e.code[id] = 1'b1;
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = pc;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        expq.push_back(e);
        if (e.ill) exp_cnt++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual in_ready=0 required accept of 0x%08h", w);
    end
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 50 && expq.size() != 0; i++) @(negedge clk);
    check(name, 64'(expq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_code"}, 64'(out_code), 64'd0);
    check({tag, "_out_illegal"}, 64'(out_illegal), 64'd0);
    check({tag, "_out_instr"}, 64'(out_instr), 64'd0);
    check({tag, "_out_pc"}, 64'(out_pc), 64'd0);
    check({tag, "_illegal_cnt"}, 64'(illegal_cnt), 64'd0);
  endtask

  initial begin
    logic [31:0] sat_words [5];
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b0; sat_valid = 1'b0; sat_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD with one-cycle latency
    out_ready = 1'b1;
    applyStimulus(32'h012A4020, 32'h0000_1000, ID_ADD);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    waitDrain("drain_add");

    // COP0 by rs, REGIMM by rt, SPECIAL2, plus ordinary I/J/R types back to back
    applyStimulus(32'h40806000, 32'h0000_1004, ID_MTC0);
    applyStimulus(32'h40026000, 32'h0000_1008, ID_MFC0);
    applyStimulus(32'h42000018, 32'h0000_100C, ID_ERET);
    applyStimulus(32'h04210004, 32'h0000_1010, ID_BGEZ);
    applyStimulus(32'h70801020, 32'h0000_1014, ID_CLZ);
    applyStimulus(32'h8C880004, 32'h0000_1018, ID_LW);
    applyStimulus(32'h08000010, 32'h0000_101C, ID_J);
    applyStimulus(32'h0109001A, 32'h0000_1020, ID_DIV);
    waitDrain("drain_mix");

    // Illegal encodings
    applyStimulus(32'hFC000000, 32'h0000_2000, -1);
    applyStimulus(32'h04020000, 32'h0000_2004, -1);
    waitDrain("drain_illegal");
    check("illegal_cnt_two", 64'(illegal_cnt), 64'd2);
    applyStimulus(32'h70801021, 32'h0000_2008, -1);
    applyStimulus(32'h40A06000, 32'h0000_200C, -1);
    applyStimulus(32'h42000019, 32'h0000_2010, -1);
    applyStimulus(32'h00000001, 32'h0000_2014, -1);
    waitDrain("drain_illegal2");
    check("illegal_cnt_six", 64'(illegal_cnt), 64'(exp_cnt));

    // Backpressure: two accepted, third stalls until release
    out_ready = 1'b0;
    applyStimulus(32'h012A4020, 32'h0000_3000, ID_ADD);
    applyStimulus(32'h8C880004, 32'h0000_3004, ID_LW);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("hold_out_instr", 64'(out_instr), 64'h012A4020);
    @(posedge clk);
    #1;
    check("hold_out_valid", 64'(out_valid), 64'd1);
    check("hold_out_pc", 64'(out_pc), 64'h0000_3000);
    fork
      applyStimulus(32'h08000010, 32'h0000_3008, ID_J);
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain("drain_backpressure");

    // Flush while holding two entries, with an illegal word offered at the same edge
    out_ready = 1'b0;
    applyStimulus(32'h40806000, 32'h0000_4000, ID_MTC0);
    applyStimulus(32'h40026000, 32'h0000_4004, ID_MFC0);
    in_valid = 1'b1;
    in_instr = 32'hFC000000;
    in_pc    = 32'h0000_4008;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    expq.delete();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_illegal_cnt", 64'(illegal_cnt), 64'(exp_cnt));
    @(posedge clk);
    #1;
    check("flush_dropped", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    applyStimulus(32'h0109001A, 32'h0000_4010, ID_DIV);
    waitDrain("drain_after_flush");

    // Saturation of a 2-bit counter
    sat_words[0] = 32'hFC000000; sat_words[1] = 32'h04020000; sat_words[2] = 32'h00000001;
    sat_words[3] = 32'h40A06000; sat_words[4] = 32'h70801021;
    sat_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sat_instr = sat_words[i];
      @(posedge clk);
      #1;
    end
    sat_valid = 1'b0;
    check("sat_cnt", 64'(sat_cnt), 64'd3);

    // Asynchronous reset in the middle of a transfer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h8C880004;
    in_pc     = 32'h0000_5000;
    @(posedge clk);
    #1;
    in_instr  = 32'hFC000000;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    expq.delete();
    exp_cnt = 0;
    checkResetOutputs("async_reset");
    check("async_reset_sat_cnt", 64'(sat_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(32'h012A4020, 32'h0000_6000, ID_ADD);
    waitDrain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
